// File: rtl/ozgun_ram_pkg.sv
// Shared definitions for the block-RAM arbiter and the RAM it drives.
//   - state_e      : arbiter FSM states (zero-fill, normal service)
//   - REQ_A/REQ_B  : bit index of each requester in req/gnt vectors
//   - DEF_*        : default RAM geometry, common to arbiter and RAM
package ozgun_ram_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_DEPTH      = 4096;

endpackage

// File: rtl/ozgun_rr_arb2.sv
// Two-way round-robin grant logic with its priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (index REQ_A / REQ_B)
//   advance    : allow the pointer to move to this cycle's winner
//   gnt[1:0]   : one-hot grant, combinational on req and the pointer
module ozgun_rr_arb2
    import ozgun_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently; the other one wins a tie.
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'(REQ_A);
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[REQ_B];
        end
    end

endmodule

// File: rtl/ozgun_ram_arbiter.sv
// Controller for a single-port block RAM shared by two requesters.
// After reset it zero-fills the RAM (optional), then serves A and B with
// round-robin arbitration, one access per cycle, and registers read data.
//   clk, rst_n            : clock, asynchronous active-low reset
//   init_done             : zero-fill finished, arbitration enabled
//   a_*/b_* req,we,addr,wdata : requester access (held until granted)
//   a_gnt/b_gnt           : access happens this cycle (combinational)
//   a_rvalid/b_rvalid     : 1-cycle pulse after a granted read
//   a_rdata/b_rdata       : registered read data, held until next read
//   ram_addr/we/wdata     : RAM drive;  ram_rdata : combinational RAM read
module ozgun_ram_arbiter
    import ozgun_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  init_done_q;
    logic                  run_en;
    logic [1:0]            req_vec;
    logic [1:0]            gnt;

    // Zero-fill sequencer and init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? StInit : StRun;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun: begin
                    init_done_q <= 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign init_done = init_done_q;

    // rst_n gates the combinational outputs so nothing reaches the RAM in reset.
    assign run_en  = rst_n && (state_q == StRun);
    assign req_vec = {b_req, a_req} & {2{run_en}};

    ozgun_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vec),
        .advance (run_en),
        .gnt     (gnt)
    );

    assign a_gnt = gnt[REQ_A];
    assign b_gnt = gnt[REQ_B];

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rst_n && (state_q == StInit)) begin
            ram_addr = cnt_q;
            ram_we   = 1'b1;
        end else if (a_gnt) begin
            ram_addr  = a_addr;
            ram_we    = a_we;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_addr  = b_addr;
            ram_we    = b_we;
            ram_wdata = b_wdata;
        end
    end

    // Read return path: capture at the grant edge, pulse rvalid next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= ram_rdata;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ozgun_ram_arbiter.sv
// Self-checking bench: one arbiter with zero-fill, one without, each driving
// its own behavioural RAM preloaded with all-ones.
module tb_ozgun_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 128;
    localparam int DEP = 16;

    logic clk;
    logic rst_n;
    logic preload;
    int   vectors;
    int   miscompares;

    // DUT 1 (CLEAR_ON_RESET = 1)
    logic          init_done1;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt1, b_gnt1, a_rvalid1, b_rvalid1;
    logic [DW-1:0] a_rdata1, b_rdata1;
    logic [AW-1:0] ram_addr1;
    logic          ram_we1;
    logic [DW-1:0] ram_wdata1, ram_rdata1;
    logic [DW-1:0] mem1 [DEP];

    // DUT 2 (CLEAR_ON_RESET = 0)
    logic          init_done2;
    logic          d2_a_req, d2_a_we, d2_b_req, d2_b_we;
    logic [AW-1:0] d2_a_addr, d2_b_addr;
    logic [DW-1:0] d2_a_wdata, d2_b_wdata;
    logic          a_gnt2, b_gnt2, a_rvalid2, b_rvalid2;
    logic [DW-1:0] a_rdata2, b_rdata2;
    logic [AW-1:0] ram_addr2;
    logic          ram_we2;
    logic [DW-1:0] ram_wdata2, ram_rdata2;
    logic [DW-1:0] mem2 [DEP];

    ozgun_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done1),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1)
    );

    ozgun_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .CLEAR_ON_RESET(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done2),
        .a_req(d2_a_req), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
        .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
        .b_req(d2_b_req), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata),
        .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2),
        .ram_rdata(ram_rdata2)
    );

    // Behavioural block RAMs: combinational read, write on rising edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEP; i++) begin
                mem1[i] <= '1;
                mem2[i] <= '1;
            end
        end else begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
            if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
        end
    end
    assign ram_rdata1 = mem1[ram_addr1];
    assign ram_rdata2 = mem2[ram_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        d2_a_req = 0; d2_a_we = 0; d2_a_addr = '0; d2_a_wdata = '0;
        d2_b_req = 0; d2_b_we = 0; d2_b_addr = '0; d2_b_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; preload = 1;
        idle_inputs();
        a_req = 1; b_req = 1; d2_a_req = 1;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (init_done1 !== 1'b0) begin miscompares++; $display("FAIL rst_init_done: got %b want 0", init_done1); end
        vectors++; if ({a_gnt1, b_gnt1} !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: got %b want 00", {a_gnt1, b_gnt1}); end
        vectors++; if (ram_we1 !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we: got %b want 0", ram_we1); end
        vectors++; if (ram_addr1 !== '0) begin miscompares++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr1); end
        vectors++; if (ram_wdata1 !== '0) begin miscompares++; $display("FAIL rst_ram_wdata: got %h want 0", ram_wdata1); end
        vectors++; if ({a_rvalid1, b_rvalid1} !== 2'b00) begin miscompares++; $display("FAIL rst_rvalid: got %b want 00", {a_rvalid1, b_rvalid1}); end
        vectors++; if ((a_rdata1 | b_rdata1) !== '0) begin miscompares++; $display("FAIL rst_rdata: got %h/%h want 0", a_rdata1, b_rdata1); end
        vectors++; if ({a_gnt2, ram_we2, init_done2} !== 3'b000) begin miscompares++; $display("FAIL rst_noclr: got %b want 000", {a_gnt2, ram_we2, init_done2}); end
        preload = 0;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_no_clear();
        @(negedge clk);
        rst_n = 1;
        #1;
        vectors++; if (init_done2 !== 1'b0) begin miscompares++; $display("FAIL noclr_done_before_edge: got %b want 0", init_done2); end
        vectors++; if (ram_we2 !== 1'b0) begin miscompares++; $display("FAIL noclr_we0: got %b want 0", ram_we2); end
        @(negedge clk);
        vectors++; if (init_done2 !== 1'b1) begin miscompares++; $display("FAIL noclr_done_after_edge: got %b want 1", init_done2); end
        vectors++; if (ram_we2 !== 1'b0) begin miscompares++; $display("FAIL noclr_we1: got %b want 0", ram_we2); end
        d2_a_req = 1; d2_a_we = 0; d2_a_addr = 4'd3;
        #1;
        vectors++; if (a_gnt2 !== 1'b1) begin miscompares++; $display("FAIL noclr_gnt: got %b want 1", a_gnt2); end
        @(negedge clk);
        d2_a_req = 0;
        vectors++; if (a_rvalid2 !== 1'b1) begin miscompares++; $display("FAIL noclr_rvalid: got %b want 1", a_rvalid2); end
        vectors++; if (a_rdata2 !== {DW{1'b1}}) begin miscompares++; $display("FAIL noclr_rdata: got %h want all ones", a_rdata2); end
    endtask

    task automatic test_init_b_req();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        b_req = 1; b_we = 0; b_addr = 4'd9;
        rst_n = 1;
        for (int i = 0; i < DEP; i++) begin
            #1;
            vectors++; if ({ram_we1, ram_addr1, ram_wdata1} !== {1'b1, AW'(i), {DW{1'b0}}}) begin
                miscompares++; $display("FAIL init_write[%0d]: got we=%b addr=%0d data=%h", i, ram_we1, ram_addr1, ram_wdata1);
            end
            vectors++; if ({b_gnt1, init_done1} !== 2'b00) begin miscompares++; $display("FAIL init_gnt_done[%0d]: got %b want 00", i, {b_gnt1, init_done1}); end
            @(negedge clk);
        end
        vectors++; if (init_done1 !== 1'b1) begin miscompares++; $display("FAIL init_done_rise: got %b want 1", init_done1); end
        #1;
        vectors++; if ({b_gnt1, ram_we1, ram_addr1} !== {1'b1, 1'b0, 4'd9}) begin
            miscompares++; $display("FAIL init_b_first_run: got gnt=%b we=%b addr=%0d", b_gnt1, ram_we1, ram_addr1);
        end
        @(negedge clk);
        b_req = 0;
        vectors++; if ({b_rvalid1, b_rdata1} !== {1'b1, {DW{1'b0}}}) begin
            miscompares++; $display("FAIL init_b_read0: got rvalid=%b rdata=%h", b_rvalid1, b_rdata1);
        end
        @(negedge clk);
        vectors++; if (b_rvalid1 !== 1'b0) begin miscompares++; $display("FAIL init_b_rvalid_pulse: got %b want 0", b_rvalid1); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] dead;
        dead = DW'(32'hDEADBEEF);
        a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = dead;
        #1;
        vectors++; if ({a_gnt1, ram_we1, ram_addr1} !== {1'b1, 1'b1, 4'd5}) begin
            miscompares++; $display("FAIL wr_gnt: got gnt=%b we=%b addr=%0d", a_gnt1, ram_we1, ram_addr1);
        end
        @(negedge clk);
        vectors++; if (a_rvalid1 !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid: got %b want 0", a_rvalid1); end
        a_we = 0;
        #1;
        vectors++; if (a_gnt1 !== 1'b1) begin miscompares++; $display("FAIL rd_gnt: got %b want 1", a_gnt1); end
        @(negedge clk);
        a_req = 0;
        vectors++; if ({a_rvalid1, a_rdata1} !== {1'b1, dead}) begin
            miscompares++; $display("FAIL rd_data: got rvalid=%b rdata=%h want 1/%h", a_rvalid1, a_rdata1, dead);
        end
        vectors++; if (b_rvalid1 !== 1'b0) begin miscompares++; $display("FAIL rd_b_quiet: got %b want 0", b_rvalid1); end
        @(negedge clk);
        vectors++; if ({a_rvalid1, a_rdata1} !== {1'b0, dead}) begin
            miscompares++; $display("FAIL rd_hold: got rvalid=%b rdata=%h", a_rvalid1, a_rdata1);
        end
    endtask

    task automatic test_alternate();
        logic [DW-1:0] dead;
        logic [1:0]    prev;
        dead = DW'(32'hDEADBEEF);
        prev = 2'b00;
        a_req = 1; a_we = 0; a_addr = 4'd5;
        b_req = 1; b_we = 0; b_addr = 4'd6;
        for (int k = 0; k < 4; k++) begin
            #1;
            // Pointer is A after A's last access, so B wins first.
            vectors++; if ({b_gnt1, a_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                miscompares++; $display("FAIL alt_gnt[%0d]: got b,a=%b", k, {b_gnt1, a_gnt1});
            end
            prev = (k % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            vectors++; if ({b_rvalid1, a_rvalid1} !== prev) begin
                miscompares++; $display("FAIL alt_rvalid[%0d]: got b,a=%b want %b", k, {b_rvalid1, a_rvalid1}, prev);
            end
        end
        a_req = 0; b_req = 0;
        vectors++; if ({a_rdata1, b_rdata1} !== {dead, {DW{1'b0}}}) begin
            miscompares++; $display("FAIL alt_rdata: got a=%h b=%h", a_rdata1, b_rdata1);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        @(negedge clk);
        rst_n = 0;
        #1;
        vectors++; if (a_rdata1 !== '0) begin miscompares++; $display("FAIL mid_rdata_clear: got %h want 0", a_rdata1); end
        @(negedge clk);
        rst_n = 1;
        repeat (7) @(negedge clk);
        #1;
        vectors++; if (ram_addr1 !== 4'd7) begin miscompares++; $display("FAIL mid_cnt7: got %0d want 7", ram_addr1); end
        rst_n = 0;
        #1;
        vectors++; if ({init_done1, ram_we1, ram_addr1} !== {1'b0, 1'b0, 4'd0}) begin
            miscompares++; $display("FAIL mid_async: got done=%b we=%b addr=%0d", init_done1, ram_we1, ram_addr1);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        vectors++; if ({ram_we1, ram_addr1} !== {1'b1, 4'd0}) begin
            miscompares++; $display("FAIL mid_restart: got we=%b addr=%0d", ram_we1, ram_addr1);
        end
        n = 0;
        while (!init_done1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL mid_init_len: got %0d cycles want 16", n); end
    endtask

    task automatic test_random();
        logic [DW-1:0] smem [DEP];
        logic          pend [2];
        logic          pwe [2];
        logic [AW-1:0] paddr [2];
        logic [DW-1:0] pwd [2];
        logic          erv [2];
        logic [DW-1:0] erd [2];
        int            last;
        int            w;
        for (int i = 0; i < DEP; i++) smem[i] = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; pwe[r] = 0; paddr[r] = '0; pwd[r] = '0; erv[r] = 0; erd[r] = '0;
        end
        last = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            vectors++; if ({a_rvalid1, b_rvalid1} !== {erv[0], erv[1]}) begin
                miscompares++; $display("FAIL rnd_rvalid[%0d]: got a,b=%b want %b", c, {a_rvalid1, b_rvalid1}, {erv[0], erv[1]});
            end
            vectors++; if ({a_rdata1, b_rdata1} !== {erd[0], erd[1]}) begin
                miscompares++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", c, a_rdata1, b_rdata1, erd[0], erd[1]);
            end
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
                    pend[r]  = 1;
                    pwe[r]   = 1'($urandom_range(1, 0));
                    paddr[r] = AW'($urandom_range(DEP - 1, 0));
                    pwd[r]   = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            a_req = pend[0]; a_we = pwe[0]; a_addr = paddr[0]; a_wdata = pwd[0];
            b_req = pend[1]; b_we = pwe[1]; b_addr = paddr[1]; b_wdata = pwd[1];
            if (pend[0] && pend[1]) w = 1 - last;
            else if (pend[0]) w = 0;
            else if (pend[1]) w = 1;
            else w = -1;
            #1;
            vectors++; if ({a_gnt1, b_gnt1} !== {w == 0, w == 1}) begin
                miscompares++; $display("FAIL rnd_gnt[%0d]: got a,b=%b want winner %0d", c, {a_gnt1, b_gnt1}, w);
            end
            erv[0] = 0; erv[1] = 0;
            if (w >= 0) begin
                last = w;
                pend[w] = 0;
                if (pwe[w]) begin
                    smem[paddr[w]] = pwd[w];
                end else begin
                    erv[w] = 1;
                    erd[w] = smem[paddr[w]];
                end
            end
        end
        @(negedge clk);
        a_req = 0; b_req = 0;
        vectors++; if ({a_rvalid1, b_rvalid1, a_rdata1, b_rdata1} !== {erv[0], erv[1], erd[0], erd[1]}) begin
            miscompares++; $display("FAIL rnd_final: got a,b rvalid=%b", {a_rvalid1, b_rvalid1});
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_no_clear();
        test_init_b_req();
        test_write_read();
        test_alternate();
        test_reset_mid_init();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
